port_rr_arbiter: RTL and testbench
==================================

# port_rr_arbiter

Output-port scheduler for the 4-port switch: one instance per output port shares that port's `valid_op`/`data_op` channel among all input-side requesters. It filters requests by the packet target field, picks one eligible requester round-robin and registers the packet onto the output. It holds the packet while the downstream `suspend_op` is asserted. A per-port delivered-packet counter supports bench checking.

## Interface

Parameters:
- `NPORTS`, 4: number of requesters (input ports).
- `DW`, 16: packet width; packet format is `{data[15:8], source[7:4], target[3:0]}`.
- `PORT_ID`, 0: index of the output port this instance serves (0..3).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `req`  in  NPORTS  requester i has a packet pending on `pkt_in` slice i.
- `pkt_in`  in  NPORTS*DW  packets; slice i = `pkt_in[i*DW +: DW]`.
- `gnt`  out  NPORTS  one-hot accept; combinational; requester i's packet is taken at this clock edge.
- `suspend_op`  in  1  downstream back-pressure; 1 = do not consume `data_op`.
- `valid_op`  out  1  `data_op` holds a packet.
- `data_op`  out  DW  packet to the output port, bit-identical to the accepted `pkt_in` slice.
- `busy`  out  1  equals `valid_op`; present for status wiring.
- `pkt_count`  out  16  number of packets delivered (transfers completed).

## Operation

- Eligible(i) = `req[i]` and `pkt_in[i*DW + PORT_ID]` (target bit for this port) is 1. A packet whose target bit is 0, including target 4'b0000, is never granted by this instance.
- Transfer = rising edge with `valid_op`=1 and `suspend_op`=0.
- `load_en` = (`valid_op`=0) or (`suspend_op`=0): the output register is empty or is emptying at this edge.
- Winner = first eligible requester scanning from `rr_ptr` upward, modulo NPORTS.
- `gnt[winner]`=1 iff `load_en` and at least one requester is eligible; all other bits are 0. `gnt` depends only on registered state, `req`, `pkt_in` and `suspend_op`.
- On an edge with any `gnt` bit set: `data_op` takes the winner's packet, `valid_op` is set to 1, and `rr_ptr` is set to (winner+1) mod NPORTS.
- On an edge with `load_en`=1 and no eligible requester: `valid_op` is set to 0. `data_op` keeps its last value, which is don't-care.
- While `valid_op`=1 and `suspend_op`=1: `data_op`, `valid_op` and `rr_ptr` are held and `gnt`=0.
- `pkt_count` increments by 1 on every transfer and wraps from 16'hFFFF to 0.
- Requester contract: hold `req` and the packet stable until the cycle `gnt[i]`=1. At that edge, either drop `req` or present the next packet.
- Multicast: each output instance grants independently. The requester side is responsible for retiring a multicast packet only after every targeted instance has granted it; that logic is not in this block.
- Two-state view:
  - EMPTY (`valid_op`=0) goes to FULL on a grant.
  - FULL goes to FULL on transfer plus grant (back-to-back), to EMPTY on transfer with no eligible request, and stays FULL while `suspend_op`=1.

## Timing

- Reset (asynchronous, `reset`=0): `valid_op`=0, `data_op`=0, `busy`=0, `pkt_count`=0, `rr_ptr`=0 (requester 0 has highest priority). `gnt`=0 while in reset.
- Deassertion of reset is synchronous to `clk` by the system. The first grant can occur at the first edge after deassertion.
- Latency: a packet appears on `data_op` 1 cycle after the `gnt` cycle.
- Throughput: 1 packet per cycle with `suspend_op`=0 and continuous eligible requests.
- Suspend: if `suspend_op` rises while FULL, the packet is held for as many cycles as it stays high. Delivery happens at the first edge with `suspend_op`=0, and a new packet can be loaded at that same edge.
- Reset asserted mid-FULL: the packet is discarded and not counted. A requester with a pending `req` must re-present it after reset.
- `rr_ptr` changes only on a grant. Requesters that drop out do not move it.

## Test plan

- Reset values: hold `reset`=0 with random `req`/`pkt_in` -> `valid_op`=0, `data_op`=0, `gnt`=0, `pkt_count`=0; release reset -> first grant goes to the lowest-index eligible requester.
- Single packet: PORT_ID=1, `req`=4'b0001, pkt0=16'hA502 -> `gnt`=4'b0001 for 1 cycle; next cycle `valid_op`=1, `data_op`=16'hA502; after the transfer `valid_op`=0 and `pkt_count`=1.
- Round robin: PORT_ID=0, all four requesters hold `req` with target 4'hF (broadcast), `suspend_op`=0 -> grant order 0,1,2,3,0,… with one grant per cycle; `pkt_count` reaches 8 after 8 transfers.
- Target filter: PORT_ID=2; pkt0 target 4'b0001, pkt1 target 4'b0000, pkt3 target 4'b0100 -> only requester 3 is granted; requesters 0 and 1 are never granted.
- Suspend: `valid_op`=1 with 16'h3C18, drive `suspend_op`=1 for 5 cycles with `req` pending -> `data_op` stable, `gnt`=0 and `pkt_count` unchanged for 5 cycles; on release, the transfer and the next grant happen at the same edge.
- Counter wrap and mid-operation reset: preload to 16'hFFFF via 65535 transfers, then one more transfer -> `pkt_count`=0; assert `reset` while FULL -> `valid_op` drops immediately without waiting for a clock edge.

Source files
------------

// File: rtl/port_rr_arbiter.sv
// Output-port scheduler: filters requesters by target bit, picks one round-robin
// and registers the winning packet onto the output channel, holding it under suspend.
module port_rr_arbiter #(
  parameter int NPORTS  = 4,
  parameter int DW      = 16,
  parameter int PORT_ID = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS*DW-1:0] pkt_in,
  output logic [NPORTS-1:0]    gnt,
  input  logic                 suspend_op,
  output logic                 valid_op,
  output logic [DW-1:0]        data_op,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0] eligible;
  logic [DW-1:0]     pkt_slice [NPORTS];

  logic              valid_reg;
  logic [DW-1:0]     data_reg;
  logic [PW-1:0]     rr_ptr_reg;
  logic [15:0]       count_reg;

  logic              load_en;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       scan_idx;
  logic [PW-1:0]     rr_ptr_next;

  // A requester is eligible only when its packet's target bit selects this port.
  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_req
      assign pkt_slice[gi] = pkt_in[gi*DW +: DW];
      assign eligible[gi]  = req[gi] & pkt_in[gi*DW + PORT_ID];
    end
  endgenerate

  // First eligible requester at or above rr_ptr, wrapping modulo NPORTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NPORTS))
        scan_idx = scan_idx - (PW+1)'(NPORTS);
      if (!win_found && eligible[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  assign load_en     = !valid_reg || !suspend_op;
  assign rr_ptr_next = (win_idx == PW'(NPORTS-1)) ? '0 : win_idx + 1'b1;

  // Reset gates gnt directly so no accept is signalled while the block is held in reset.
  always_comb begin
    gnt = '0;
    if (load_en && win_found && reset)
      gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      rr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (valid_reg && !suspend_op)
        count_reg <= count_reg + 16'd1;
      if (load_en) begin
        valid_reg <= win_found;
        if (win_found) begin
          data_reg   <= pkt_slice[win_idx];
          rr_ptr_reg <= rr_ptr_next;
        end
      end
    end
  end

  assign valid_op  = valid_reg;
  assign busy      = valid_reg;
  assign data_op   = data_reg;
  assign pkt_count = count_reg;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Four arbiter instances (one per output port) share the requesters; each is
// compared against a per-port transaction-level model of the scheduling rules.
module tb_port_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NP-1:0]    req_r;
  logic [DW-1:0]    pkt_r [NP];
  logic [NP*DW-1:0] pkt_bus;
  logic [NP-1:0]    susp;

  logic [NP-1:0] gnt_w   [NP];
  logic          valid_w [NP];
  logic [DW-1:0] data_w  [NP];
  logic          busy_w  [NP];
  logic [15:0]   cnt_w   [NP];

  assign pkt_bus = {pkt_r[3], pkt_r[2], pkt_r[1], pkt_r[0]};

  for (genvar gi = 0; gi < NP; gi++) begin : g_dut
    port_rr_arbiter #(.NPORTS(NP), .DW(DW), .PORT_ID(gi)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req_r),
      .pkt_in    (pkt_bus),
      .gnt       (gnt_w[gi]),
      .suspend_op(susp[gi]),
      .valid_op  (valid_w[gi]),
      .data_op   (data_w[gi]),
      .busy      (busy_w[gi]),
      .pkt_count (cnt_w[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: each output port is a one-slot buffer with a priority pointer.
  int          m_valid [NP];
  int          m_ptr   [NP];
  int          m_win   [NP];
  int          m_cnt   [NP];
  bit          m_load  [NP];
  logic [15:0] m_data  [NP];
  logic [NP-1:0] obs_gnt [NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_valid[p] = 0; m_ptr[p] = 0; m_cnt[p] = 0; m_data[p] = 16'h0;
    end
  endtask

  task automatic model_eval();
    for (int p = 0; p < NP; p++) begin
      m_load[p] = (m_valid[p] == 0) || (susp[p] == 1'b0);
      m_win[p]  = -1;
      for (int k = 0; k < NP; k++) begin
        int i = (m_ptr[p] + k) % NP;
        if (m_win[p] < 0 && req_r[i] && pkt_r[i][p]) m_win[p] = i;
      end
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int p);
    return (m_load[p] && m_win[p] >= 0) ? (32'(1) << m_win[p]) : 32'd0;
  endfunction

  task automatic model_update();
    for (int p = 0; p < NP; p++) begin
      if (m_valid[p] != 0 && !susp[p]) m_cnt[p] = (m_cnt[p] + 1) % 65536;
      if (m_load[p]) begin
        if (m_win[p] >= 0) begin
          m_data[p]  = pkt_r[m_win[p]];
          m_valid[p] = 1;
          m_ptr[p]   = (m_win[p] + 1) % NP;
        end else begin
          m_valid[p] = 0;
        end
      end
    end
  endtask

  // One clock: called at a falling edge with inputs already driven, returns at the next one.
  task automatic step(input bit chk_en);
    #1;
    model_eval();
    for (int p = 0; p < NP; p++) begin
      obs_gnt[p] = gnt_w[p];
      if (chk_en) chk($sformatf("gnt[p%0d]", p), 32'(gnt_w[p]), exp_gnt(p));
    end
    @(posedge clk);
    model_update();
    #1;
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("valid[p%0d]", p), 32'(valid_w[p]), 32'(m_valid[p]));
        chk($sformatf("busy[p%0d]", p),  32'(busy_w[p]),  32'(m_valid[p]));
        chk($sformatf("cnt[p%0d]", p),   32'(cnt_w[p]),   32'(m_cnt[p]));
        if (m_valid[p] != 0) chk($sformatf("data[p%0d]", p), 32'(data_w[p]), 32'(m_data[p]));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic new_pkt(input int i);
    req_r[i] = 1'b1;
    pkt_r[i] = {8'($urandom), 4'(i), 4'($urandom_range(0, 15))};
  endtask

  bit seen3;
  bit granted;
  int cs;

  initial begin
    reset = 1'b0;
    req_r = '0;
    susp  = '0;
    for (int i = 0; i < NP; i++) pkt_r[i] = '0;
    model_reset();

    // Reset values with random traffic applied during reset
    repeat (3) @(negedge clk);
    req_r = 4'($urandom);
    susp  = 4'($urandom);
    for (int i = 0; i < NP; i++) pkt_r[i] = 16'($urandom);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk("rst_valid", 32'(valid_w[p]), 32'd0);
      chk("rst_busy",  32'(busy_w[p]),  32'd0);
      chk("rst_data",  32'(data_w[p]),  32'd0);
      chk("rst_gnt",   32'(gnt_w[p]),   32'd0);
      chk("rst_cnt",   32'(cnt_w[p]),   32'd0);
    end
    @(negedge clk);

    // First grant after release goes to the lowest-index eligible requester
    req_r = 4'b1010; susp = '0;
    pkt_r[1] = 16'h111F; pkt_r[3] = 16'h333F;
    reset = 1'b1;
    step(1);
    for (int p = 0; p < NP; p++) chk("first_gnt", 32'(obs_gnt[p]), 32'b0010);
    req_r = '0;
    step(1);
    step(1);

    // Single packet to port 1
    req_r = 4'b0001; pkt_r[0] = 16'hA502;
    step(1);
    chk("single_gnt", 32'(obs_gnt[1]), 32'b0001);
    chk("single_other", 32'(obs_gnt[0] | obs_gnt[2] | obs_gnt[3]), 32'd0);
    chk("single_valid", 32'(valid_w[1]), 32'd1);
    chk("single_data", 32'(data_w[1]), 32'hA502);
    req_r = '0;
    step(1);
    chk("single_drain", 32'(valid_w[1]), 32'd0);
    chk("single_cnt", 32'(cnt_w[1]), 32'd2);

    // Round robin on port 0 with all requesters broadcasting
    do_reset();
    for (int i = 0; i < NP; i++) pkt_r[i] = {8'(8'h40 + i), 4'(i), 4'hF};
    req_r = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step(1);
      if (k < 8) chk($sformatf("rr_order%0d", k), 32'(obs_gnt[0]), 32'(1) << (k % 4));
    end
    chk("rr_cnt8", 32'(cnt_w[0]), 32'd8);

    // Target filter on port 2
    req_r = '0;
    step(1); step(1);
    pkt_r[0] = 16'hA001; pkt_r[1] = 16'hB110; pkt_r[3] = 16'hD334;
    pkt_r[1][3:0] = 4'b0000;
    req_r = 4'b1011;
    seen3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("filter_no01", 32'(obs_gnt[2] & 4'b0011), 32'd0);
      seen3 |= obs_gnt[2][3];
    end
    chk("filter_gnt3", 32'(seen3), 32'd1);

    // Suspend on port 3
    req_r = '0;
    step(1); step(1);
    pkt_r[0] = 16'h3C18; req_r = 4'b0001;
    step(1);
    pkt_r[2] = 16'h5528; req_r = 4'b0100; susp[3] = 1'b1;
    cs = m_cnt[3];
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("susp_gnt", 32'(obs_gnt[3]), 32'd0);
      chk("susp_data", 32'(data_w[3]), 32'h3C18);
      chk("susp_cnt", 32'(cnt_w[3]), 32'(cs));
    end
    susp[3] = 1'b0;
    step(1);
    chk("release_gnt", 32'(obs_gnt[3]), 32'b0100);
    chk("release_cnt", 32'(cnt_w[3]), 32'(cs + 1));
    chk("release_data", 32'(data_w[3]), 32'h5528);

    // Counter wrap with continuous broadcast traffic
    req_r = '0;
    do_reset();
    for (int i = 0; i < NP; i++) pkt_r[i] = {8'(8'h70 + i), 4'(i), 4'hF};
    req_r = 4'b1111; susp = '0;
    repeat (65536) step(0);
    for (int p = 0; p < NP; p++) chk("wrap_ffff", 32'(cnt_w[p]), 32'hFFFF);
    step(1);
    for (int p = 0; p < NP; p++) chk("wrap_zero", 32'(cnt_w[p]), 32'd0);

    // Reset while FULL clears the output without a clock edge
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < NP; p++) begin
      chk("midrst_valid", 32'(valid_w[p]), 32'd0);
      chk("midrst_gnt",   32'(gnt_w[p]),   32'd0);
      chk("midrst_cnt",   32'(cnt_w[p]),   32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic and back-pressure
    for (int i = 0; i < NP; i++) new_pkt(i);
    for (int c = 0; c < 1000; c++) begin
      for (int p = 0; p < NP; p++) susp[p] = ($urandom_range(0, 3) == 0);
      step(1);
      for (int i = 0; i < NP; i++) begin
        granted = 1'b0;
        for (int p = 0; p < NP; p++) granted |= obs_gnt[p][i];
        if (granted) begin
          if ($urandom_range(0, 3) != 0) new_pkt(i);
          else req_r[i] = 1'b0;
        end else if (!req_r[i] && $urandom_range(0, 2) == 0) begin
          new_pkt(i);
        end else if ($urandom_range(0, 15) == 0) begin
          new_pkt(i);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
